pwm_update_sched: RTL



---
 rtl/pwm_update_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_update_sched.sv
// pwm_update_sched: captures SPI width commands, clamps them to servo limits,
// slews both PWM compare values once per period, and falls back to neutral
// when commands stop arriving.
module pwm_update_sched #(
  parameter int unsigned MIN_W           = 24000,
  parameter int unsigned MAX_W           = 48000,
  parameter int unsigned NEUTRAL_W       = 36000,
  parameter int unsigned STEP            = 240,
  parameter int unsigned TIMEOUT_PERIODS = 25
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        period_start,
  output logic [15:0] width_1,
  output logic [15:0] width_2,
  output logic        ramping,
  output logic        failsafe,
  output logic        clamp_evt
);

  typedef enum logic {
    ST_SAFE,
    ST_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] w1_q, w1_d, w2_q, w2_d;
  logic [15:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ramp_q, ramp_d;
  logic        clamp_q, clamp_d;
  logic        accept;
  logic [15:0] f1, f2;
  logic        c1, c2;

  // Map a raw command field onto a legal target: 0 = off, else [MIN_W, MAX_W].
  function automatic logic [15:0] clamp_field(input logic [15:0] f);
    logic [15:0] r;
    if (f == '0)                  r = '0;
    else if (f < 16'(MIN_W))      r = 16'(MIN_W);
    else if (f > 16'(MAX_W))      r = 16'(MAX_W);
    else                          r = f;
    return r;
  endfunction

  function automatic logic field_clamped(input logic [15:0] f);
    return (f != '0) && ((f < 16'(MIN_W)) || (f > 16'(MAX_W)));
  endfunction

  // One bounded step toward the target in 17-bit arithmetic; never overshoots.
  function automatic logic [16:0] slew(input logic [16:0] w, input logic [16:0] t);
    logic [16:0] r;
    logic [16:0] diff;
    diff = '0;
    if (t == '0) begin
      r = '0;
    end else if (w == '0) begin
      r = t;
    end else if (t >= w) begin
      diff = t - w;
      r    = (diff <= 17'(STEP)) ? t : w + 17'(STEP);
    end else begin
      diff = w - t;
      r    = (diff <= 17'(STEP)) ? t : w - 17'(STEP);
    end
    return r;
  endfunction

  assign cmd_ready = !RST;
  assign accept    = cmd_valid && cmd_ready;
  assign f1        = cmd_data[31:16];
  assign f2        = cmd_data[15:0];
  assign c1        = field_clamped(f1);
  assign c2        = field_clamped(f2);

  // Next-state: width updates use the pre-command targets; a command beats
  // both a simultaneous period_start count and a pending timeout.
  always_comb begin
    state_d = state_q;
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    cnt_d   = cnt_q;
    w1_d    = w1_q;
    w2_d    = w2_q;

    if (period_start) begin
      w1_d = 16'(slew({1'b0, w1_q}, {1'b0, tgt1_q}));
      w2_d = 16'(slew({1'b0, w2_q}, {1'b0, tgt2_q}));
    end

    if (accept) begin
      tgt1_d  = clamp_field(f1);
      tgt2_d  = clamp_field(f2);
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_RUN && TIMEOUT_PERIODS != 0) begin
      if (cnt_q == 32'(TIMEOUT_PERIODS)) begin
        tgt1_d  = 16'(NEUTRAL_W);
        tgt2_d  = 16'(NEUTRAL_W);
        state_d = ST_SAFE;
        cnt_d   = '0;
      end else if (period_start) begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    clamp_d = accept && (c1 || c2);
    ramp_d  = (w1_d != tgt1_d) || (w2_d != tgt2_d);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SAFE;
      w1_q    <= 16'(NEUTRAL_W);
      w2_q    <= 16'(NEUTRAL_W);
      tgt1_q  <= 16'(NEUTRAL_W);
      tgt2_q  <= 16'(NEUTRAL_W);
      cnt_q   <= '0;
      ramp_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      clamp_q <= clamp_d;
    end
  end

  assign width_1   = w1_q;
  assign width_2   = w2_q;
  assign ramping   = ramp_q;
  assign failsafe  = (state_q == ST_SAFE);
  assign clamp_evt = clamp_q;

endmodule
